// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-port ALU sharing controller.
// Flag packing is common to the ALU flags input and the response flags output.
package alu_ctrl_pkg;

  localparam int unsigned DATA_W_DFLT  = 5;
  localparam int unsigned SEL_W_DFLT   = 5;
  localparam int unsigned RES_W_DFLT   = 8;
  localparam int unsigned NUM_OPS_DFLT = 13;
  localparam int unsigned FLAG_W       = 6;

  localparam int unsigned FLAG_CARRY    = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_NEGATIVE = 2;
  localparam int unsigned FLAG_LESS     = 3;
  localparam int unsigned FLAG_EQUAL    = 4;
  localparam int unsigned FLAG_ZERO     = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester opposite the last grant wins.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: arbitrate, register operands,
// capture result/flags one cycle later, and return them over a valid/ready response.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DFLT,
  parameter int unsigned SEL_W   = SEL_W_DFLT,
  parameter int unsigned RES_W   = RES_W_DFLT,
  parameter int unsigned NUM_OPS = NUM_OPS_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RES_W-1:0]  alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              busy
);

  localparam logic [SEL_W-1:0] NumOpsSel = SEL_W'(NUM_OPS);

  state_e            state_q;
  logic              owner_q;
  logic              last_grant_q;
  logic              err_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [SEL_W-1:0]  alu_sel_q;
  logic [RES_W-1:0]  rsp_result_q;
  logic [FLAG_W-1:0] rsp_flags_q;
  logic              rsp_err_q;

  logic [1:0]        gnt;
  logic              win;
  logic              req_hs;
  logic              rsp_hs;
  logic [DATA_W-1:0] win_a, win_b;
  logic [SEL_W-1:0]  win_sel;

  rr_arb2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  // Readiness depends only on state and valids; masked while reset is held.
  assign req0_ready = (state_q == StIdle) && gnt[0] && !reset;
  assign req1_ready = (state_q == StIdle) && gnt[1] && !reset;
  assign req_hs     = req0_ready || req1_ready;
  assign win        = gnt[1];
  assign win_a      = win ? req1_a   : req0_a;
  assign win_b      = win ? req1_b   : req0_b;
  assign win_sel    = win ? req1_sel : req0_sel;
  assign rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_hs) begin
            owner_q      <= win;
            last_grant_q <= win;
            alu_a_q      <= win_a;
            alu_b_q      <= win_b;
            if (win_sel >= NumOpsSel) begin
              err_q     <= 1'b1;
              alu_sel_q <= '0;
            end else begin
              err_q     <= 1'b0;
              alu_sel_q <= win_sel;
            end
            state_q <= StExec;
          end
        end
        StExec: begin
          if (err_q) begin
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b1;
          end else begin
            rsp_result_q <= alu_result;
            rsp_flags_q  <= alu_flags;
            rsp_err_q    <= 1'b0;
          end
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_hs) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp0_valid = (state_q == StResp) && !owner_q;
  assign rsp1_valid = (state_q == StResp) && owner_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a simple ALU stub (sel 0 = add).
module tb_alu_share_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0] req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp_result;
  logic [5:0] rsp_flags;
  logic       rsp_err;
  logic [4:0] alu_a, alu_b, alu_sel;
  logic [7:0] alu_result;
  logic [5:0] alu_flags;
  logic       busy;
  logic [5:0] flags_stub;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign alu_result = (alu_sel == 5'd0) ? ({3'b0, alu_a} + {3'b0, alu_b}) : 8'h00;
  assign alu_flags  = flags_stub;

  alu_share_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    flags_stub = '0;
    tick(); tick();
    chk("rst_busy",   32'(busy), 0);
    chk("rst_rsp0v",  32'(rsp0_valid), 0);
    chk("rst_rsp1v",  32'(rsp1_valid), 0);
    chk("rst_alu_a",  32'(alu_a), 0);
    chk("rst_result", 32'(rsp_result), 0);
    reset = 1'b0;
    tick();

    // Single request on port 0: 10 + 11
    req0_valid = 1'b1; req0_a = 5'd10; req0_b = 5'd11; req0_sel = 5'd0;
    #1;
    chk("t1_req0_ready", 32'(req0_ready), 1);
    chk("t1_req1_ready", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    chk("t1_alu_a", 32'(alu_a), 10);
    chk("t1_alu_b", 32'(alu_b), 11);
    chk("t1_busy",  32'(busy), 1);
    chk("t1_rsp0v_exec", 32'(rsp0_valid), 0);
    tick();
    chk("t1_rsp0v",   32'(rsp0_valid), 1);
    chk("t1_rsp1v",   32'(rsp1_valid), 0);
    chk("t1_result",  32'(rsp_result), 21);
    chk("t1_err",     32'(rsp_err), 0);
    tick();
    chk("t1_rsp0v_done", 32'(rsp0_valid), 0);
    chk("t1_busy_done",  32'(busy), 0);
    chk("t1_alu_a_hold", 32'(alu_a), 10);

    // Fresh reset so the tie-break starts from last_grant = 1
    reset = 1'b1; #2; reset = 1'b0;
    req0_valid = 1'b1; req0_a = 5'd1; req0_b = 5'd2; req0_sel = 5'd0;
    req1_valid = 1'b1; req1_a = 5'd3; req1_b = 5'd4; req1_sel = 5'd0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_req0_ready", 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
      chk("rr_req1_ready", 32'(req1_ready), (i % 2 == 1) ? 1 : 0);
      tick();
      chk("rr_alu_a", 32'(alu_a), (i % 2 == 0) ? 1 : 3);
      tick();
      chk("rr_rsp0v",   32'(rsp0_valid), (i % 2 == 0) ? 1 : 0);
      chk("rr_rsp1v",   32'(rsp1_valid), (i % 2 == 1) ? 1 : 0);
      chk("rr_result",  32'(rsp_result), (i % 2 == 0) ? 3 : 7);
      chk("rr_ready_resp", 32'({req1_ready, req0_ready}), 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Illegal opcode on port 1: result/flags zeroed, err set, alu_sel forced to 0
    flags_stub = 6'h3f;
    req1_valid = 1'b1; req1_a = 5'd3; req1_b = 5'd4; req1_sel = 5'd20;
    #1;
    chk("ill_req1_ready", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    chk("ill_alu_sel", 32'(alu_sel), 0);
    chk("ill_alu_a",   32'(alu_a), 3);
    tick();
    chk("ill_rsp1v",   32'(rsp1_valid), 1);
    chk("ill_rsp0v",   32'(rsp0_valid), 0);
    chk("ill_result",  32'(rsp_result), 0);
    chk("ill_flags",   32'(rsp_flags), 0);
    chk("ill_err",     32'(rsp_err), 1);
    tick();
    flags_stub = 6'h00;

    // Backpressure on port 0 while port 1 waits
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 5'd6; req0_b = 5'd7; req0_sel = 5'd0;
    #1;
    chk("bp_req0_ready", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b1; req1_a = 5'd2; req1_b = 5'd2; req1_sel = 5'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp0v",   32'(rsp0_valid), 1);
      chk("bp_result",  32'(rsp_result), 13);
      chk("bp_err",     32'(rsp_err), 0);
      chk("bp_req1_ready", 32'(req1_ready), 0);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp_req1_ready_hs", 32'(req1_ready), 0);
    tick();
    chk("bp_rsp0v_done",    32'(rsp0_valid), 0);
    chk("bp_req1_ready_ok", 32'(req1_ready), 1);
    tick();
    chk("bp_alu_a_req1", 32'(alu_a), 2);
    chk("bp_busy_exec",  32'(busy), 1);

    // Reset asserted during EXEC
    reset = 1'b1;
    #1;
    chk("rx_busy",   32'(busy), 0);
    chk("rx_rsp1v",  32'(rsp1_valid), 0);
    chk("rx_alu_a",  32'(alu_a), 0);
    chk("rx_result", 32'(rsp_result), 0);
    chk("rx_ready",  32'({req1_ready, req0_ready}), 0);
    tick();
    chk("rx_rsp1v_held", 32'(rsp1_valid), 0);
    reset = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Tie after reset goes to port 0; flags pass through unchanged
    flags_stub = 6'b010001;
    req0_valid = 1'b1; req0_a = 5'd5; req0_b = 5'd5; req0_sel = 5'd0;
    req1_valid = 1'b1; req1_a = 5'd1; req1_b = 5'd1; req1_sel = 5'd0;
    #1;
    chk("fl_req0_ready", 32'(req0_ready), 1);
    chk("fl_req1_ready", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("fl_rsp0v",   32'(rsp0_valid), 1);
    chk("fl_result",  32'(rsp_result), 10);
    chk("fl_flags",   32'(rsp_flags), 32'h11);
    chk("fl_carry",   32'(rsp_flags[0]), 1);
    chk("fl_equal",   32'(rsp_flags[4]), 1);
    chk("fl_zero",    32'(rsp_flags[5]), 0);
    tick();
    chk("fl_busy_done", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
